// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU memory request into re/we bus cycles, with
// load extension, store lane steering, misalignment handling and optional RMW.
module load_store_unit #(
    parameter int XLEN          = 32,
    parameter int ADDR_W        = 32,
    parameter int BYTE_EN_MODE  = 0,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [XLEN-1:0]   write_data,
    input  logic [XLEN-1:0]   read_data,
    output logic [XLEN/8-1:0] be,
    output logic              re,
    output logic              we,
    input  logic              mem_busy
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;
    state_t state_reg;

    logic             store_reg;
    logic [2:0]       funct3_reg;
    logic [XLEN-1:0]  wdata_reg;
    logic [OFF_W-1:0] off_reg;

    logic [OFF_W-1:0] req_off, req_mask, req_off_al;
    logic             req_illegal, req_misaligned, req_err, req_full;

    always_comb begin
        req_off        = req_addr[OFF_W-1:0];
        req_mask       = OFF_W'((32'd1 << req_funct3[1:0]) - 32'd1);
        req_off_al     = req_off & ~req_mask;
        req_illegal    = (req_funct3 == 3'b111)
                      || ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110))
                      || (req_store && req_funct3[2]);
        req_misaligned = (req_off & req_mask) != '0;
        req_err        = req_illegal || (req_misaligned && (MISALIGN_TRAP != 0));
        req_full       = (XLEN == 64) ? (req_funct3[1:0] == 2'b11) : (req_funct3[1:0] == 2'b10);
    end

    // In IDLE the lane logic looks at the live request so a direct store can
    // be driven on the acceptance edge; afterwards it uses the latched copy.
    logic [OFF_W-1:0] cur_off;
    logic [2:0]       cur_funct3;
    logic [XLEN-1:0]  cur_wdata, store_sh, strobe_data, merged_data;
    logic [NB-1:0]    lane_en;
    int               cur_size;

    always_comb begin
        cur_off    = (state_reg == IDLE) ? req_off_al : off_reg;
        cur_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
        cur_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
        cur_size   = 1 << cur_funct3[1:0];
        store_sh   = cur_wdata << {cur_off, 3'b000};
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_en[gi] = (gi >= int'(cur_off)) && (gi < int'(cur_off) + cur_size);
            assign strobe_data[gi*8 +: 8] = lane_en[gi] ? store_sh[gi*8 +: 8] : 8'h00;
            assign merged_data[gi*8 +: 8] = lane_en[gi] ? store_sh[gi*8 +: 8] : read_data[gi*8 +: 8];
        end
    endgenerate

    // Load extraction: move the addressed bytes to the bottom, then push them
    // to the top and shift back down to sign- or zero-extend.
    logic [XLEN-1:0]        ld_sh, ld_zext, ld_result;
    logic signed [XLEN-1:0] ld_left, ld_sext;
    int                     ext_sh;

    always_comb begin
        ext_sh    = XLEN - 8 * (1 << funct3_reg[1:0]);
        ld_sh     = read_data >> {off_reg, 3'b000};
        ld_left   = ld_sh << ext_sh;
        ld_sext   = ld_left >>> ext_sh;
        ld_zext   = (ld_sh << ext_sh) >> ext_sh;
        ld_result = funct3_reg[2] ? ld_zext : ld_sext;
    end

    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            store_reg  <= 1'b0;
            funct3_reg <= '0;
            wdata_reg  <= '0;
            off_reg    <= '0;
            re         <= 1'b0;
            we         <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            address    <= '0;
            write_data <= '0;
            be         <= '0;
        end else begin
            re         <= 1'b0;
            we         <= 1'b0;
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg  <= req_store;
                        funct3_reg <= req_funct3;
                        wdata_reg  <= req_wdata;
                        off_reg    <= req_off_al;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state_reg  <= RESP;
                        end else begin
                            address <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            if (!req_store || (!req_full && BYTE_EN_MODE == 0)) begin
                                re        <= 1'b1;
                                state_reg <= RD_ISSUE;
                            end else begin
                                we         <= 1'b1;
                                write_data <= strobe_data;
                                be         <= (BYTE_EN_MODE != 0) ? lane_en : '1;
                                state_reg  <= WR_ISSUE;
                            end
                        end
                    end
                end
                RD_ISSUE: state_reg <= RD_WAIT;
                RD_WAIT: begin
                    if (!(mem_busy || re)) begin
                        if (store_reg) begin
                            we         <= 1'b1;
                            write_data <= merged_data;
                            be         <= '1;
                            state_reg  <= WR_ISSUE;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= ld_result;
                            state_reg  <= RESP;
                        end
                    end
                end
                WR_ISSUE: state_reg <= WR_WAIT;
                WR_WAIT: begin
                    if (!(mem_busy || we)) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a 32-bit RMW/trapping unit and a 64-bit byte-strobe,
// force-aligning unit, each on a small bus memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic load_mem = 1'b1;

    logic        a_req_valid = 0, a_req_store = 0, a_mem_busy = 0;
    logic [2:0]  a_req_funct3 = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic        a_req_ready, a_resp_valid, a_resp_err, a_re, a_we;
    logic [31:0] a_resp_rdata, a_address, a_write_data, a_read_data;
    logic [3:0]  a_be;

    logic        b_req_valid = 0, b_req_store = 0, b_mem_busy = 0;
    logic [2:0]  b_req_funct3 = 0;
    logic [31:0] b_req_addr = 0;
    logic [63:0] b_req_wdata = 0;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_re, b_we;
    logic [63:0] b_resp_rdata, b_write_data, b_read_data;
    logic [31:0] b_address;
    logic [7:0]  b_be;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .BYTE_EN_MODE(0), .MISALIGN_TRAP(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_store(a_req_store), .req_funct3(a_req_funct3), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .address(a_address), .write_data(a_write_data),
        .read_data(a_read_data), .be(a_be), .re(a_re), .we(a_we), .mem_busy(a_mem_busy));

    load_store_unit #(.XLEN(64), .ADDR_W(32), .BYTE_EN_MODE(1), .MISALIGN_TRAP(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_store(b_req_store), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .address(b_address), .write_data(b_write_data),
        .read_data(b_read_data), .be(b_be), .re(b_re), .we(b_we), .mem_busy(b_mem_busy));

    logic [31:0] mem_a [0:255];
    logic [63:0] mem_b [0:63];
    assign a_read_data = mem_a[a_address[9:2]];
    assign b_read_data = mem_b[b_address[8:3]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
            for (int i = 0; i < 64; i++) mem_b[i] <= 64'h0;
            mem_a[8'h40] <= 32'h80FF7F01;
            mem_a[8'h80] <= 32'h11223344;
            mem_b[6'h41] <= 64'h12345678_FFFFFFFF;
        end else begin
            for (int i = 0; i < 4; i++)
                if (a_we && a_be[i]) mem_a[a_address[9:2]][i*8 +: 8] <= a_write_data[i*8 +: 8];
            for (int i = 0; i < 8; i++)
                if (b_we && b_be[i]) mem_b[b_address[8:3]][i*8 +: 8] <= b_write_data[i*8 +: 8];
        end
    end

    // Strobe activity counters and overlap / back-to-back strobe detector.
    int a_re_n = 0, a_we_n = 0, a_rv_n = 0, bad_n = 0;
    logic a_re_q = 0, a_we_q = 0, b_re_q = 0, b_we_q = 0;
    always @(posedge clk) begin
        if (a_re) a_re_n++;
        if (a_we) a_we_n++;
        if (a_resp_valid) a_rv_n++;
        if ((a_re && a_we) || (b_re && b_we) || (a_re && a_re_q) || (a_we && a_we_q)
            || (b_re && b_re_q) || (b_we && b_we_q)) bad_n++;
        a_re_q <= a_re; a_we_q <= a_we; b_re_q <= b_re; b_we_q <= b_we;
    end

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          r_re, r_we, r_resp, r_rdy;
    logic [63:0] r_rdata, r_wdata;
    logic [31:0] r_raddr, r_waddr;
    logic [7:0]  r_be;
    logic        r_err;

    // Issue one request (called at a negedge while idle) and record the cycle
    // numbers of re/we/resp_valid relative to the acceptance edge.
    task automatic run(input bit sel, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input int bs, input int bl);
        logic o_re, o_we, o_rv, o_rdy;
        r_re = 0; r_we = 0; r_resp = 0; r_rdy = 0; r_rdata = '0; r_wdata = '0;
        r_raddr = '0; r_waddr = '0; r_be = '0; r_err = 1'b0;
        if (sel) begin
            b_req_valid = 1; b_req_store = st; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1; a_req_store = st; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd[31:0];
        end
        for (int cyc = 1; cyc <= 30 && r_resp == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin a_req_valid = 0; b_req_valid = 0; end
            o_re  = sel ? b_re : a_re;
            o_we  = sel ? b_we : a_we;
            o_rv  = sel ? b_resp_valid : a_resp_valid;
            o_rdy = sel ? b_req_ready : a_req_ready;
            if (o_rdy) r_rdy++;
            if (o_re) begin
                if (r_re == 0) r_re = cyc;
                r_raddr = sel ? b_address : a_address;
            end
            if (o_we) begin
                if (r_we == 0) r_we = cyc;
                r_waddr = sel ? b_address : a_address;
                r_wdata = sel ? b_write_data : {32'h0, a_write_data};
                r_be    = sel ? b_be : {4'h0, a_be};
            end
            if (o_rv) begin
                r_resp  = cyc;
                r_rdata = sel ? b_resp_rdata : {32'h0, a_resp_rdata};
                r_err   = sel ? b_resp_err : a_resp_err;
            end
            a_mem_busy = !sel && cyc >= bs && cyc < bs + bl;
            b_mem_busy = sel && cyc >= bs && cyc < bs + bl;
        end
        a_mem_busy = 0; b_mem_busy = 0;
        @(negedge clk);
    endtask

    int re0, we0, rv0;
    initial begin
        repeat (2) @(negedge clk);
        load_mem = 0;
        chk("rst_a_ctl", {a_req_ready, a_re, a_we, a_resp_valid, a_resp_err}, 5'b10000);
        chk("rst_a_bus", {a_address, a_write_data}, 64'h0);
        chk("rst_a_be_rdata", {a_be, a_resp_rdata}, 36'h0);
        chk("rst_b_ctl", {b_req_ready, b_re, b_we, b_resp_valid, b_resp_err, b_be}, 13'h1000);
        rst = 0;
        @(negedge clk);

        run(0, 0, 3'b000, 32'h101, 0, 0, 0);
        chk("lb101_re_cyc", r_re, 1);   chk("lb101_addr", r_raddr, 32'h100);
        chk("lb101_resp_cyc", r_resp, 3); chk("lb101_rdata", r_rdata, 64'h7F);
        chk("lb101_we", r_we, 0);        chk("lb101_err", r_err, 0);
        run(0, 0, 3'b000, 32'h103, 0, 0, 0);
        chk("lb103_rdata", r_rdata, 64'hFFFFFF80);
        run(0, 0, 3'b101, 32'h102, 0, 0, 0);
        chk("lhu102_rdata", r_rdata, 64'h80FF);

        run(0, 1, 3'b000, 32'h202, 64'hAA, 0, 0);
        chk("sb_rmw_re_cyc", r_re, 1);   chk("sb_rmw_we_cyc", r_we, 3);
        chk("sb_rmw_wdata", r_wdata, 64'h11AA3344); chk("sb_rmw_be", r_be, 8'hF);
        chk("sb_rmw_waddr", r_waddr, 32'h200); chk("sb_rmw_resp_cyc", r_resp, 5);
        chk("sb_rmw_rdata", r_rdata, 0);
        run(0, 1, 3'b010, 32'h108, 64'hDEADBEEF, 0, 0);
        chk("sw_re", r_re, 0);           chk("sw_we_cyc", r_we, 1);
        chk("sw_wdata", r_wdata, 64'hDEADBEEF); chk("sw_be", r_be, 8'hF);
        chk("sw_resp_cyc", r_resp, 3);

        run(0, 0, 3'b010, 32'h301, 0, 0, 0);
        chk("lw_mis_resp_cyc", r_resp, 1); chk("lw_mis_err", r_err, 1);
        chk("lw_mis_strobes", {r_re, r_we}, 0);
        run(0, 0, 3'b011, 32'h100, 0, 0, 0);
        chk("ld32_err", r_err, 1);      chk("ld32_resp_cyc", r_resp, 1);
        chk("ld32_rdata", r_rdata, 0);
        run(0, 1, 3'b100, 32'h100, 64'h1, 0, 0);
        chk("st_f3_4_err", r_err, 1);   chk("st_f3_4_we", r_we, 0);

        run(0, 0, 3'b010, 32'h100, 0, 2, 4);
        chk("lw_busy_resp_cyc", r_resp, 7); chk("lw_busy_rdata", r_rdata, 64'h80FF7F01);
        chk("lw_busy_ready", r_rdy, 0);
        run(0, 0, 3'b010, 32'h200, 0, 0, 0);
        chk("lw_after_rmw", r_rdata, 64'h11AA3344);

        run(1, 1, 3'b001, 32'h206, 64'hBEEF, 0, 0);
        chk("sh64_re", r_re, 0);        chk("sh64_we_cyc", r_we, 1);
        chk("sh64_waddr", r_waddr, 32'h200);
        chk("sh64_wdata", r_wdata, 64'hBEEF0000_00000000); chk("sh64_be", r_be, 8'hC0);
        chk("sh64_resp_cyc", r_resp, 3);
        run(1, 0, 3'b110, 32'h208, 0, 0, 0);
        chk("lwu64_rdata", r_rdata, 64'h00000000_FFFFFFFF); chk("lwu64_addr", r_raddr, 32'h208);
        run(1, 0, 3'b010, 32'h20C, 0, 0, 0);
        chk("lw64_hi_rdata", r_rdata, 64'h12345678);
        run(1, 0, 3'b010, 32'h208, 0, 0, 0);
        chk("lw64_sext", r_rdata, 64'hFFFFFFFF_FFFFFFFF);
        run(1, 0, 3'b101, 32'h20D, 0, 0, 0);
        chk("lhu64_forcealign", r_rdata, 64'h5678); chk("lhu64_err", r_err, 0);
        run(1, 1, 3'b001, 32'h201, 64'h1234, 0, 0);
        chk("sh64_fa_wdata", r_wdata, 64'h1234); chk("sh64_fa_be", r_be, 8'h03);
        run(1, 0, 3'b011, 32'h200, 0, 0, 0);
        chk("ld64_rdata", r_rdata, 64'hBEEF0000_00001234);
        run(1, 0, 3'b000, 32'h207, 0, 0, 0);
        chk("lb64_sext", r_rdata, 64'hFFFFFFFF_FFFFFFBE);

        // Reset while an RMW store's read is outstanding.
        a_req_valid = 1; a_req_store = 1; a_req_funct3 = 3'b000; a_req_addr = 32'h200; a_req_wdata = 32'h55;
        @(negedge clk);
        a_req_valid = 0;
        chk("rstmid_re", a_re, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstmid_ctl", {a_req_ready, a_re, a_we, a_resp_valid, a_resp_err}, 5'b10000);
        chk("rstmid_bus", {a_address, a_write_data}, 64'h0);
        chk("rstmid_be_rdata", {a_be, a_resp_rdata}, 36'h0);
        re0 = a_re_n; we0 = a_we_n; rv0 = a_rv_n;
        repeat (10) @(negedge clk);
        chk("rstmid_no_strobe", {a_re_n - re0, a_we_n - we0}, 64'h0);
        chk("rstmid_no_resp", a_rv_n - rv0, 0);
        chk("rstmid_mem", mem_a[8'h80], 64'h11AA3344);

        chk("strobe_rules", bad_n, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
